// File: rtl/rmon_pkg.sv
// Shared definitions for the RMON statistics block: RAM geometry, CPU bus width
// and the CPU reader state encoding.
package rmon_pkg;

    localparam int RMON_AW = 6;
    localparam int RMON_DW = 32;
    localparam int CPU_DW  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } rd_state_t;

    function automatic logic [CPU_DW-1:0] pick_half(input logic [RMON_DW-1:0] word,
                                                    input logic               hi);
        return hi ? word[RMON_DW-1:CPU_DW] : word[CPU_DW-1:0];
    endfunction

endpackage

// File: rtl/rmon_cpu_reader.sv
// CPU-side reader for the RMON counter RAM: fetches a 32-bit counter over port B
// and serves it as two 16-bit halves from a coherent snapshot register.
module rmon_cpu_reader
    import rmon_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int AW     = RMON_AW
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [AW:0]        CPU_rd_addr,
    input  logic               CPU_rd_apply,
    output logic               CPU_rd_grant,
    output logic [CPU_DW-1:0]  CPU_rd_dout,
    output logic [AW-1:0]      Addrb,
    input  logic [RMON_DW-1:0] Doutb,
    output logic               Snap_valid
);

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT - 1);

    rd_state_t          state;
    rd_state_t          next_state;
    logic               armed;
    logic [AW-1:0]      req_idx;
    logic               req_half;
    logic [2:0]         lat_cnt;
    logic [RMON_DW-1:0] snap_word;
    logic [AW-1:0]      snap_idx;
    logic               snap_hit;
    logic               enter_done;
    logic [RMON_DW-1:0] src_word;
    logic               src_half;

    // A high-half request for the word already held is served without touching the RAM.
    assign snap_hit = CPU_rd_addr[0] && Snap_valid && (CPU_rd_addr[AW:1] == snap_idx);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (CPU_rd_apply && armed) begin
                    next_state = snap_hit ? DONE : ADDR;
                end
            end
            ADDR:    next_state = WAIT;
            WAIT:    if (lat_cnt == 3'd0) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Returned half comes straight from the RAM on a fetch, otherwise from the snapshot.
    assign enter_done = (next_state == DONE) && (state != DONE);
    assign src_word   = (state == WAIT) ? Doutb : snap_word;
    assign src_half   = (state == WAIT) ? req_half : CPU_rd_addr[0];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            req_idx    <= '0;
            req_half   <= 1'b0;
            lat_cnt    <= 3'd0;
            Addrb      <= '0;
            snap_word  <= '0;
            snap_idx   <= '0;
            Snap_valid <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (next_state != IDLE) begin
                        req_idx  <= CPU_rd_addr[AW:1];
                        req_half <= CPU_rd_addr[0];
                    end
                end
                ADDR: begin
                    Addrb   <= req_idx;
                    lat_cnt <= LAT_INIT;
                end
                WAIT: begin
                    if (lat_cnt == 3'd0) begin
                        snap_word  <= Doutb;
                        snap_idx   <= req_idx;
                        Snap_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Grant and data are registered on entry to DONE, so both are stable for the whole DONE cycle;
    // armed blocks a repeat grant until the CPU releases its request.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            CPU_rd_grant <= 1'b0;
            CPU_rd_dout  <= '0;
            armed        <= 1'b1;
        end else begin
            CPU_rd_grant <= enter_done && CPU_rd_apply;
            if (enter_done && CPU_rd_apply) begin
                CPU_rd_dout <= pick_half(src_word, src_half);
            end
            if (!CPU_rd_apply) begin
                armed <= 1'b1;
            end else if (CPU_rd_grant) begin
                armed <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rmon_cpu_reader.sv
// Directed and randomized checks of rmon_cpu_reader against a word-level snapshot model,
// with a registered-address RAM on a skewed port-B clock.
module tb_rmon_cpu_reader;
    import rmon_pkg::*;

    localparam int RD_LAT = 2;
    localparam int AW     = 6;

    logic              clk = 1'b0;
    logic              clkb;
    logic              rst_n;
    logic [AW:0]       cpu_addr;
    logic              apply;
    logic              grant;
    logic [15:0]       dout;
    logic [AW-1:0]     addrb;
    logic [31:0]       doutb;
    logic              snap_valid;

    logic [31:0]       ram [64];
    logic [AW-1:0]     ram_addr_r;

    int check_count = 0;
    int pass_count  = 0;
    int fail_count  = 0;

    bit          m_snap_ok;
    int          m_snap_idx;
    logic [31:0] m_snap_word;

    always #5 clk = ~clk;
    assign #2 clkb = clk;

    always @(posedge clkb) ram_addr_r <= addrb;
    assign doutb = ram[ram_addr_r];

    rmon_cpu_reader #(.RD_LAT(RD_LAT), .AW(AW)) dut (
        .Clk          (clk),
        .Reset        (rst_n),
        .CPU_rd_addr  (cpu_addr),
        .CPU_rd_apply (apply),
        .CPU_rd_grant (grant),
        .CPU_rd_dout  (dout),
        .Addrb        (addrb),
        .Doutb        (doutb),
        .Snap_valid   (snap_valid)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Model: a high-half read of the held word is a 1-cycle hit, anything else refetches the RAM.
    task automatic modelRead(input int idx, input bit half, output bit hit,
                             output int lat, output logic [15:0] data);
        hit = half && m_snap_ok && (m_snap_idx == idx);
        if (!hit) begin
            m_snap_word = ram[idx];
            m_snap_idx  = idx;
            m_snap_ok   = 1'b1;
        end
        lat  = hit ? 1 : RD_LAT + 2;
        data = half ? m_snap_word[31:16] : m_snap_word[15:0];
    endtask

    task automatic applyStimulus(input int idx, input bit half, input string tag);
        bit            hit;
        bit            got;
        int            exp_lat;
        int            lat;
        logic [15:0]   exp_data;
        logic [AW-1:0] prev_addrb;
        logic [5:0]    idx6;
        modelRead(idx, half, hit, exp_lat, exp_data);
        prev_addrb = addrb;
        idx6       = idx[5:0];
        cpu_addr   = {idx6, half};
        apply      = 1'b1;
        got        = 1'b0;
        lat        = 0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(posedge clk); #1;
            if (grant) begin
                got = 1'b1;
                lat = k;
            end
        end
        checkOutput({tag, " grant"}, 32'(got), 32'd1);
        checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, " dout"}, 32'(dout), 32'(exp_data));
        checkOutput({tag, " addrb"}, 32'(addrb), hit ? 32'(prev_addrb) : 32'(idx6));
        checkOutput({tag, " snap_valid"}, 32'(snap_valid), 32'd1);
        apply = 1'b0;
        @(posedge clk); #1;
        checkOutput({tag, " grant one cycle"}, 32'(grant), 32'd0);
        checkOutput({tag, " dout hold"}, 32'(dout), 32'(exp_data));
    endtask

    initial begin
        int            grants;
        bit            hit;
        int            lat;
        logic [15:0]   exp_data;
        logic [15:0]   held;

        for (int i = 0; i < 64; i++) ram[i] = $urandom;
        rst_n    = 1'b0;
        apply    = 1'b0;
        cpu_addr = '0;
        m_snap_ok = 1'b0;
        m_snap_idx = 0;
        m_snap_word = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset grant", 32'(grant), 32'd0);
        checkOutput("reset dout", 32'(dout), 32'd0);
        checkOutput("reset addrb", 32'(addrb), 32'd0);
        checkOutput("reset snap_valid", 32'(snap_valid), 32'd0);

        // Reset in the middle of a fetch wipes the snapshot and issues no grant
        applyStimulus(7, 1'b0, "pre-reset read");
        cpu_addr = {6'd3, 1'b0};
        apply    = 1'b1;
        grants   = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (grant) grants++;
        end
        apply = 1'b0;
        rst_n = 1'b1;
        m_snap_ok = 1'b0;
        @(posedge clk); #1;
        if (grant) grants++;
        checkOutput("mid-wait reset grants", 32'(grants), 32'd0);
        checkOutput("mid-wait reset dout", 32'(dout), 32'd0);
        checkOutput("mid-wait reset addrb", 32'(addrb), 32'd0);
        checkOutput("mid-wait reset snap_valid", 32'(snap_valid), 32'd0);

        ram[5] = 32'h1234_ABCD;
        applyStimulus(5, 1'b0, "idx5 low fetch");
        applyStimulus(5, 1'b1, "idx5 high hit");

        ram[5] = 32'h9999_0000;
        applyStimulus(5, 1'b1, "idx5 high stale");
        applyStimulus(5, 1'b0, "idx5 low refetch");
        applyStimulus(5, 1'b1, "idx5 high new");

        ram[6] = 32'hDEAD_BEEF;
        applyStimulus(6, 1'b1, "idx6 high miss");

        // Apply held long after the grant must not produce a second grant
        ram[9] = $urandom;
        modelRead(9, 1'b0, hit, lat, exp_data);
        cpu_addr = {6'd9, 1'b0};
        apply    = 1'b1;
        grants   = 0;
        repeat (RD_LAT + 2 + 20) begin
            @(posedge clk); #1;
            if (grant) grants++;
        end
        checkOutput("held apply grants", 32'(grants), 32'd1);
        checkOutput("held apply dout", 32'(dout), 32'(exp_data));
        apply = 1'b0;
        @(posedge clk); #1;
        applyStimulus(9, 1'b0, "re-raised apply");

        // Dropping apply mid-fetch completes the read silently
        ram[12] = $urandom;
        held    = dout;
        modelRead(12, 1'b0, hit, lat, exp_data);
        cpu_addr = {6'd12, 1'b0};
        apply    = 1'b1;
        repeat (3) @(posedge clk);
        #1 apply = 1'b0;
        grants = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (grant) grants++;
        end
        checkOutput("dropped apply grants", 32'(grants), 32'd0);
        checkOutput("dropped apply dout", 32'(dout), 32'(held));
        applyStimulus(12, 1'b1, "after drop high");
        applyStimulus(12, 1'b0, "after drop low");

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) == 0) ram[$urandom_range(0, 3)] = $urandom;
            applyStimulus(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "random");
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
